mem_access_stage: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register outputs: performs the data-memory access

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/mem_timeout_counter.sv | 38 +++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the MEM stage: FSM state, datapath widths and the
// control bits that travel on into the MEM/WB register.
package pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
    } memwb_ctrl_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on the data memory; expired_o flags the last
// permitted ACCESS cycle so the stage can abort instead of stalling forever.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

    // Saturate at the expiry value so the count never wraps past the abort point.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests over req/ack, stalls upstream
// while the access is outstanding and loads the MEM/WB register.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    input  logic [XLEN-1:0]       ALUResult_i,
    input  logic [XLEN-1:0]       WriteData_i,
    input  logic [REG_ADDR_W-1:0] RdAddr_i,
    input  logic                  RegWrite_i,
    input  logic                  MemToReg_i,
    input  logic                  MemWrite_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [XLEN-1:0]       dmem_addr_o,
    output logic [XLEN-1:0]       dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic                  valid_o,
    output logic                  RegWrite_o,
    output logic                  MemToReg_o,
    output logic [XLEN-1:0]       ReadData_o,
    output logic [XLEN-1:0]       ALUResult_o,
    output logic [REG_ADDR_W-1:0] RdAddr_o,
    output logic                  err_o
);

    state_e                  state_q, state_d;
    logic [XLEN-1:0]         addr_q, addr_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic                    we_q, we_d;
    memwb_ctrl_t             capCtrl_q, capCtrl_d;
    logic [REG_ADDR_W-1:0]   capRd_q, capRd_d;

    logic                    valid_q, valid_d;
    memwb_ctrl_t             wbCtrl_q, wbCtrl_d;
    logic [XLEN-1:0]         rdata_q, rdata_d;
    logic [XLEN-1:0]         aluOut_q, aluOut_d;
    logic [REG_ADDR_W-1:0]   rdOut_q, rdOut_d;
    logic                    err_q, err_d;

    logic memop;
    logic stall;
    logic cntClear;
    logic cntEnable;
    logic expired;

    assign memop = valid_i & (MemToReg_i | MemWrite_i);

    mem_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .expired_o(expired)
    );

    // MEM/WB defaults to a bubble; only a pass-through or a completed access overrides it.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        capCtrl_d = capCtrl_q;
        capRd_d   = capRd_q;
        valid_d   = 1'b0;
        wbCtrl_d  = '0;
        rdata_d   = '0;
        aluOut_d  = '0;
        rdOut_d   = '0;
        err_d     = err_q;
        stall     = 1'b0;
        cntClear  = 1'b0;
        cntEnable = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop) begin
                    if (ALUResult_i[1:0] == 2'b00) begin
                        stall              = 1'b1;
                        cntClear           = 1'b1;
                        addr_d             = ALUResult_i;
                        wdata_d            = WriteData_i;
                        we_d               = MemWrite_i;
                        capCtrl_d.RegWrite = RegWrite_i;
                        capCtrl_d.MemToReg = MemToReg_i;
                        capRd_d            = RdAddr_i;
                        state_d            = ACCESS;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    valid_d           = valid_i;
                    wbCtrl_d.RegWrite = RegWrite_i & valid_i;
                    wbCtrl_d.MemToReg = MemToReg_i & valid_i;
                    aluOut_d          = ALUResult_i;
                    rdOut_d           = RdAddr_i;
                end
            end
            ACCESS: begin
                if (dmem_ack_i) begin
                    valid_d  = 1'b1;
                    wbCtrl_d = capCtrl_q;
                    rdata_d  = capCtrl_q.MemToReg ? dmem_rdata_i : '0;
                    aluOut_d = addr_q;
                    rdOut_d  = capRd_q;
                    state_d  = IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall     = 1'b1;
                    cntEnable = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            capCtrl_q <= '0;
            capRd_q   <= '0;
            valid_q   <= 1'b0;
            wbCtrl_q  <= '0;
            rdata_q   <= '0;
            aluOut_q  <= '0;
            rdOut_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            capCtrl_q <= capCtrl_d;
            capRd_q   <= capRd_d;
            valid_q   <= valid_d;
            wbCtrl_q  <= wbCtrl_d;
            rdata_q   <= rdata_d;
            aluOut_q  <= aluOut_d;
            rdOut_q   <= rdOut_d;
            err_q     <= err_d;
        end
    end

    // Stall is combinational, so gate it with reset to release upstream immediately.
    assign stall_o      = rst_n_i & stall;
    assign dmem_req_o   = (state_q == ACCESS);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign valid_o      = valid_q;
    assign RegWrite_o   = wbCtrl_q.RegWrite;
    assign MemToReg_o   = wbCtrl_q.MemToReg;
    assign ReadData_o   = rdata_q;
    assign ALUResult_o  = aluOut_q;
    assign RdAddr_o     = rdOut_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a scoreboard queue holds the MEM/WB
// entry each instruction should produce, popped when valid_o rises.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic [31:0] ALUResult_i;
    logic [31:0] WriteData_i;
    logic [4:0]  RdAddr_i;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic        MemWrite_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic        RegWrite_o;
    logic        MemToReg_o;
    logic [31:0] ReadData_o;
    logic [31:0] ALUResult_o;
    logic [4:0]  RdAddr_o;
    logic        err_o;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        rw;
        logic        m2r;
    } wb_t;

    wb_t scoreQ[$];
    int  totalCount = 0;
    int  badCount   = 0;

    mem_access_stage #(
        .TIMEOUT(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .valid_i     (valid_i),
        .ALUResult_i (ALUResult_i),
        .WriteData_i (WriteData_i),
        .RdAddr_i    (RdAddr_i),
        .RegWrite_i  (RegWrite_i),
        .MemToReg_i  (MemToReg_i),
        .MemWrite_i  (MemWrite_i),
        .stall_o     (stall_o),
        .dmem_req_o  (dmem_req_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_addr_o (dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i  (dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i),
        .valid_o     (valid_o),
        .RegWrite_o  (RegWrite_o),
        .MemToReg_o  (MemToReg_o),
        .ReadData_o  (ReadData_o),
        .ALUResult_o (ALUResult_o),
        .RdAddr_o    (RdAddr_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic wb_t sample_wb();
        wb_t s;
        s.alu   = ALUResult_o;
        s.rd    = RdAddr_o;
        s.rdata = ReadData_o;
        s.rw    = RegWrite_o;
        s.m2r   = MemToReg_o;
        return s;
    endfunction

    task automatic drive_idle();
        valid_i      = 1'b0;
        ALUResult_i  = '0;
        WriteData_i  = '0;
        RdAddr_i     = '0;
        RegWrite_i   = 1'b0;
        MemToReg_i   = 1'b0;
        MemWrite_i   = 1'b0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
    endtask

    task automatic drive_alu(input logic [31:0] alu, input logic [4:0] rd);
        valid_i     = 1'b1;
        ALUResult_i = alu;
        WriteData_i = 32'hCAFE_0000;
        RdAddr_i    = rd;
        RegWrite_i  = 1'b1;
        MemToReg_i  = 1'b0;
        MemWrite_i  = 1'b0;
        scoreQ.push_back('{alu: alu, rd: rd, rdata: 32'h0, rw: 1'b1, m2r: 1'b0});
    endtask

    task automatic test_reset();
        wb_t obs;
        rst_n_i = 1'b0;
        drive_idle();
        #2;
        totalCount++;
        if ({valid_o, dmem_req_o, stall_o, err_o, dmem_we_o} !== 5'b0) begin
            badCount++;
            $display("[TB] FAIL reset_ctrl got=%b exp=00000", {valid_o, dmem_req_o, stall_o, err_o, dmem_we_o});
        end
        obs = sample_wb();
        totalCount++;
        if (obs !== '0) begin
            badCount++;
            $display("[TB] FAIL reset_wb got=%h exp=0", obs);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_passthrough();
        wb_t exp;
        drive_alu(32'h0000_0010, 5'd5);
        #1;
        totalCount++;
        if (stall_o !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL pass_stall got=%b exp=0", stall_o);
        end
        @(posedge clk_i); #1;
        drive_idle();
        totalCount++;
        if (valid_o !== 1'b1) begin
            badCount++;
            $display("[TB] FAIL pass_valid got=%b exp=1", valid_o);
        end
        exp = scoreQ.pop_front();
        totalCount++;
        if (sample_wb() !== exp) begin
            badCount++;
            $display("[TB] FAIL pass_wb got=%h exp=%h", sample_wb(), exp);
        end
    endtask

    // ackAfter = number of ACCESS cycles without ack before the acked one
    task automatic do_mem_access(input string name, input logic isStore, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd, input logic rw,
                                 input logic [31:0] rdata, input int ackAfter);
        wb_t  exp;
        int   stallCnt;
        logic acked;
        exp.alu   = addr;
        exp.rd    = rd;
        exp.rdata = isStore ? 32'h0 : rdata;
        exp.rw    = rw;
        exp.m2r   = !isStore;
        scoreQ.push_back(exp);
        valid_i     = 1'b1;
        ALUResult_i = addr;
        WriteData_i = wdata;
        RdAddr_i    = rd;
        RegWrite_i  = rw;
        MemToReg_i  = !isStore;
        MemWrite_i  = isStore;
        stallCnt    = 0;
        acked       = 1'b0;
        for (int k = 0; k < 20 && !acked; k++) begin
            dmem_ack_i   = (k == ackAfter + 1);
            dmem_rdata_i = dmem_ack_i ? rdata : 32'hBAD0_BAD0;
            if (k >= 1) begin
                ALUResult_i = ~addr;
                WriteData_i = ~wdata;
            end
            #1;
            totalCount++;
            if (k == 0 && dmem_req_o !== 1'b0) begin
                badCount++;
                $display("[TB] FAIL %s_req_accept got=%b exp=0", name, dmem_req_o);
            end
            if (k >= 1 && {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o} !== {1'b1, isStore, addr, wdata}) begin
                badCount++;
                $display("[TB] FAIL %s_bus k=%0d got=%b/%b/%h/%h exp=1/%b/%h/%h", name, k,
                         dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, isStore, addr, wdata);
            end
            if (stall_o === 1'b1) stallCnt++;
            if (dmem_ack_i) acked = 1'b1;
            @(posedge clk_i); #1;
        end
        drive_idle();
        totalCount++;
        if (stallCnt != ackAfter + 1) begin
            badCount++;
            $display("[TB] FAIL %s_stall_cycles got=%0d exp=%0d", name, stallCnt, ackAfter + 1);
        end
        totalCount++;
        if (valid_o !== 1'b1 || scoreQ.size() == 0) begin
            badCount++;
            $display("[TB] FAIL %s_valid got=%b exp=1", name, valid_o);
        end else begin
            exp = scoreQ.pop_front();
            totalCount++;
            if (sample_wb() !== exp) begin
                badCount++;
                $display("[TB] FAIL %s_wb got=%h exp=%h", name, sample_wb(), exp);
            end
        end
    endtask

    task automatic test_load();
        do_mem_access("load", 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 32'hDEAD_BEEF, 3);
    endtask

    task automatic test_store();
        do_mem_access("store", 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd0, 1'b0, 32'h5555_AAAA, 0);
    endtask

    task automatic test_back_to_back();
        wb_t exp;
        do_mem_access("b2b_load", 1'b0, 32'h0000_0040, 32'h0, 5'd3, 1'b1, 32'h0BAD_F00D, 0);
        for (int i = 0; i < 4; i++) begin
            drive_alu(32'h1000_0001 + 32'(i * 7), 5'(i + 10));
            dmem_ack_i   = (i == 2);
            dmem_rdata_i = 32'hFFFF_FFFF;
            #1;
            totalCount++;
            if ({stall_o, dmem_req_o} !== 2'b00) begin
                badCount++;
                $display("[TB] FAIL b2b_idle i=%0d got=%b exp=00", i, {stall_o, dmem_req_o});
            end
            @(posedge clk_i); #1;
            exp = scoreQ.pop_front();
            totalCount++;
            if (valid_o !== 1'b1 || sample_wb() !== exp) begin
                badCount++;
                $display("[TB] FAIL b2b_wb i=%0d got=%b/%h exp=1/%h", i, valid_o, sample_wb(), exp);
            end
        end
        drive_idle();
        RegWrite_i = 1'b1;
        @(posedge clk_i); #1;
        totalCount++;
        if ({valid_o, RegWrite_o} !== 2'b00) begin
            badCount++;
            $display("[TB] FAIL bubble got=%b exp=00", {valid_o, RegWrite_o});
        end
        drive_idle();
    endtask

    task automatic test_timeout();
        wb_t exp;
        int  reqCnt;
        totalCount++;
        if (err_o !== 1'b0) begin
            badCount++;
            $display("[TB] FAIL timeout_err_pre got=%b exp=0", err_o);
        end
        valid_i     = 1'b1;
        ALUResult_i = 32'h0000_0300;
        RdAddr_i    = 5'd4;
        RegWrite_i  = 1'b1;
        MemToReg_i  = 1'b1;
        reqCnt      = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (dmem_req_o === 1'b1) reqCnt++;
            totalCount++;
            if (stall_o !== (k <= 3)) begin
                badCount++;
                $display("[TB] FAIL timeout_stall k=%0d got=%b exp=%b", k, stall_o, (k <= 3));
            end
            @(posedge clk_i); #1;
        end
        totalCount++;
        if (reqCnt != 4 || {dmem_req_o, err_o, valid_o} !== 3'b010) begin
            badCount++;
            $display("[TB] FAIL timeout_abort got=%0d/%b exp=4/010", reqCnt, {dmem_req_o, err_o, valid_o});
        end
        drive_idle();
        drive_alu(32'h0000_0055, 5'd9);
        @(posedge clk_i); #1;
        drive_idle();
        exp = scoreQ.pop_front();
        totalCount++;
        if (valid_o !== 1'b1 || sample_wb() !== exp) begin
            badCount++;
            $display("[TB] FAIL timeout_next got=%b/%h exp=1/%h", valid_o, sample_wb(), exp);
        end
    endtask

    task automatic test_misaligned();
        wb_t exp;
        valid_i     = 1'b1;
        ALUResult_i = 32'h0000_0103;
        RdAddr_i    = 5'd6;
        RegWrite_i  = 1'b1;
        MemToReg_i  = 1'b1;
        #1;
        totalCount++;
        if ({stall_o, dmem_req_o} !== 2'b00) begin
            badCount++;
            $display("[TB] FAIL misalign_stall got=%b exp=00", {stall_o, dmem_req_o});
        end
        @(posedge clk_i); #1;
        drive_idle();
        totalCount++;
        if ({err_o, valid_o, dmem_req_o} !== 3'b100) begin
            badCount++;
            $display("[TB] FAIL misalign_err got=%b exp=100", {err_o, valid_o, dmem_req_o});
        end
        drive_alu(32'h0000_0077, 5'd12);
        @(posedge clk_i); #1;
        drive_idle();
        exp = scoreQ.pop_front();
        totalCount++;
        if (err_o !== 1'b1 || sample_wb() !== exp) begin
            badCount++;
            $display("[TB] FAIL misalign_sticky got=%b/%h exp=1/%h", err_o, sample_wb(), exp);
        end
    endtask

    task automatic test_reset_mid_access();
        valid_i     = 1'b1;
        ALUResult_i = 32'h0000_0400;
        RdAddr_i    = 5'd8;
        RegWrite_i  = 1'b1;
        MemToReg_i  = 1'b1;
        @(posedge clk_i); #1;
        totalCount++;
        if (dmem_req_o !== 1'b1) begin
            badCount++;
            $display("[TB] FAIL rst_pre_req got=%b exp=1", dmem_req_o);
        end
        #1;
        rst_n_i = 1'b0;
        #1;
        totalCount++;
        if ({dmem_req_o, valid_o, stall_o, err_o} !== 4'b0000) begin
            badCount++;
            $display("[TB] FAIL rst_mid got=%b exp=0000", {dmem_req_o, valid_o, stall_o, err_o});
        end
        drive_idle();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        totalCount++;
        if (dmem_req_o !== 1'b0 || scoreQ.size() != 0) begin
            badCount++;
            $display("[TB] FAIL rst_post got=%b/%0d exp=0/0", dmem_req_o, scoreQ.size());
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
